// File: rtl/ias_sequencer.sv
// rtl/ias_sequencer.sv - fetch/decode/execute controller for the 8-bit IAS datapath
//
// Purpose:
//   Owns PC and IR. Fetches two-byte instructions (opcode byte, then operand
//   address byte) over a req/ready memory handshake. Decodes the opcode and
//   issues one-cycle load/ALU strobes to the AC/MQ datapath. The datapath is
//   driven only by this block.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   start      in   begin execution from RESET_PC (honoured in IDLE or HALT only)
//   mem_ready  in   memory accepts/completes the current request
//   mem_rdata  in   read data, valid when mem_req & mem_ready & !mem_we
//   ac_sign    in   AC MSB, tested by JUMP+
//   mem_req    out  memory request
//   mem_we     out  1 = write (data taken from AC by the datapath), 0 = read
//   mem_addr   out  request address
//   load_ac    out  AC <= mem_rdata
//   load_mq    out  MQ <= mem_rdata
//   mq_to_ac   out  AC <= MQ
//   add_enable out  AC <= AC + mem_rdata
//   sub_enable out  AC <= AC - mem_rdata
//   pc         out  current program counter
//   ir_opcode  out  latched opcode
//   busy       out  high in any state other than IDLE/HALT
//   halted     out  high in HALT
//   illegal    out  sticky flag: HALT was entered through an undefined opcode
module ias_sequencer #(
  parameter int                   ADDR_W   = 8,
  parameter int                   DATA_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ac_sign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              load_ac,
  output logic              load_mq,
  output logic              mq_to_ac,
  output logic              add_enable,
  output logic              sub_enable,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir_opcode,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [DATA_W-1:0] OP_HALT    = DATA_W'(8'h00);
  localparam logic [DATA_W-1:0] OP_LOAD    = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_ADD     = DATA_W'(8'h05);
  localparam logic [DATA_W-1:0] OP_SUB     = DATA_W'(8'h06);
  localparam logic [DATA_W-1:0] OP_LOAD_MQ = DATA_W'(8'h09);
  localparam logic [DATA_W-1:0] OP_MQ_AC   = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] OP_JUMP    = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] OP_JUMPP   = DATA_W'(8'h0F);
  localparam logic [DATA_W-1:0] OP_STOR    = DATA_W'(8'h21);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_OP   = 3'd1,
    S_F_ADR  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   x_q, x_d;
  logic                illegal_q, illegal_d;

  // All request outputs are decoded from state, so the async reset removes
  // mem_req in the same cycle it is asserted and abandons any open access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      x_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      x_q       <= x_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    x_d        = x_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    load_ac    = 1'b0;
    load_mq    = 1'b0;
    mq_to_ac   = 1'b0;
    add_enable = 1'b0;
    sub_enable = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_F_OP;
        end
      end

      S_HALT: begin
        if (start) begin
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
          state_d   = S_F_OP;
        end
      end

      S_F_OP: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          state_d = S_F_ADR;
        end
      end

      S_F_ADR: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          x_d     = ADDR_W'(mem_rdata);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_F_OP;
        case (ir_q)
          OP_HALT:    state_d = S_HALT;
          OP_LOAD,
          OP_LOAD_MQ,
          OP_ADD,
          OP_SUB,
          OP_STOR:    state_d = S_EXEC;
          OP_MQ_AC:   mq_to_ac = 1'b1;  // register-only op, no memory access
          OP_JUMP:    pc_d = x_q;
          OP_JUMPP: begin
            if (!ac_sign) begin
              pc_d = x_q;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        mem_req  = 1'b1;
        mem_addr = x_q;
        mem_we   = (ir_q == OP_STOR);
        // Strobe only on the transfer edge so the datapath captures valid rdata.
        if (mem_ready) begin
          case (ir_q)
            OP_LOAD:    load_ac    = 1'b1;
            OP_LOAD_MQ: load_mq    = 1'b1;
            OP_ADD:     add_enable = 1'b1;
            OP_SUB:     sub_enable = 1'b1;
            default:    ;
          endcase
          state_d = S_F_OP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pc        = pc_q;
  assign ir_opcode = ir_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ias_sequencer.sv
// tb/tb_ias_sequencer.sv - directed self-checking bench for ias_sequencer
module tb_ias_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       ac_sign;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic       load_ac;
  logic       load_mq;
  logic       mq_to_ac;
  logic       add_enable;
  logic       sub_enable;
  logic [7:0] pc;
  logic [7:0] ir_opcode;
  logic       busy;
  logic       halted;
  logic       illegal;

  logic [7:0] mem [0:255];
  logic [4:0] strobes;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign strobes   = {load_ac, load_mq, mq_to_ac, add_enable, sub_enable};

  ias_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ac_sign    (ac_sign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .load_ac    (load_ac),
    .load_mq    (load_mq),
    .mq_to_ac   (mq_to_ac),
    .add_enable (add_enable),
    .sub_enable (sub_enable),
    .pc         (pc),
    .ir_opcode  (ir_opcode),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // After kick() the DUT is in cycle 1 (first F_OP cycle).
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    ac_sign   = 1'b0;
    clear_mem();

    // 1: async reset mid-F_OP
    do_reset();
    kick();
    check_eq("t1_req_in_fop", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("t1_req_async_drop", {31'd0, mem_req}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check_eq("t1_busy", {31'd0, busy}, 32'd0);
    check_eq("t1_pc", {24'd0, pc}, 32'h00);
    check_eq("t1_halted", {31'd0, halted}, 32'd0);
    check_eq("t1_strobes", {27'd0, strobes}, 32'd0);
    check_eq("t1_ir", {24'd0, ir_opcode}, 32'h00);

    // 2: LOAD 10 / ADD 11 / HALT with zero-wait memory
    clear_mem();
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h10;
    mem[8'h02] = 8'h05; mem[8'h03] = 8'h11;
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h04;
    mem_ready = 1'b1;
    do_reset();
    kick();
    step(); step();
    check_eq("t2_c3_no_strobe", {27'd0, strobes}, 32'd0);
    step();
    check_eq("t2_c4_load_ac", {27'd0, strobes}, 32'b10000);
    check_eq("t2_c4_rdata", {24'd0, mem_rdata}, 32'h03);
    step(); step(); step(); step();
    check_eq("t2_c8_add", {27'd0, strobes}, 32'b00010);
    check_eq("t2_c8_rdata", {24'd0, mem_rdata}, 32'h04);
    step(); step(); step(); step();
    check_eq("t2_halted", {31'd0, halted}, 32'd1);
    check_eq("t2_pc", {24'd0, pc}, 32'h06);
    check_eq("t2_busy", {31'd0, busy}, 32'd0);
    check_eq("t2_illegal", {31'd0, illegal}, 32'd0);

    // 3: STOR 20 with three wait cycles
    clear_mem();
    mem[8'h00] = 8'h21; mem[8'h01] = 8'h20;
    mem_ready = 1'b1;
    do_reset();
    kick();
    step(); step();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      check_eq($sformatf("t3_hold%0d", i), {22'd0, mem_req, mem_we, mem_addr}, {22'd0, 1'b1, 1'b1, 8'h20});
      check_eq($sformatf("t3_nostrobe%0d", i), {27'd0, strobes}, 32'd0);
      step();
    end
    check_eq("t3_next_fop", {22'd0, mem_req, mem_we, mem_addr}, {22'd0, 1'b1, 1'b0, 8'h02});

    // 4: JUMP+ taken and not taken
    clear_mem();
    mem[8'h00] = 8'h0F; mem[8'h01] = 8'h40;
    mem_ready = 1'b1;
    ac_sign = 1'b0;
    do_reset();
    kick();
    step(); step(); step();
    check_eq("t4_taken_addr", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h40});
    ac_sign = 1'b1;
    do_reset();
    kick();
    step(); step(); step();
    check_eq("t4_not_taken_addr", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h02});
    ac_sign = 1'b0;

    // 5: illegal opcode, then restart
    clear_mem();
    mem[8'h00] = 8'h77; mem[8'h01] = 8'h00;
    do_reset();
    kick();
    step(); step(); step();
    check_eq("t5_halted", {31'd0, halted}, 32'd1);
    check_eq("t5_illegal", {31'd0, illegal}, 32'd1);
    kick();
    check_eq("t5_illegal_cleared", {31'd0, illegal}, 32'd0);
    check_eq("t5_restart_addr", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h00});

    // 6: PC wrap from FF to 00, start ignored while busy
    clear_mem();
    mem[8'h00] = 8'h0D; mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h01;
    do_reset();
    kick();
    step(); step(); step();
    check_eq("t6_fetch_ff", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'hFF});
    mem[8'h00] = 8'h10;
    step();
    check_eq("t6_wrap_addr", {24'd0, mem_addr}, 32'h00);
    check_eq("t6_wrap_rdata", {24'd0, mem_rdata}, 32'h10);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t6_pc_after_wrap", {24'd0, pc}, 32'h01);
    check_eq("t6_start_ignored", {31'd0, busy}, 32'd1);
    step();
    check_eq("t6_exec_addr", {24'd0, mem_addr}, 32'h10);
    check_eq("t6_exec_load", {27'd0, strobes}, 32'b10000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
